bt_pipe_initiator: RTL and testbench
====================================

Name: bt_pipe_initiator

Overview:
Synthesizable initiator for the block-throttled pipe protocol: the host-side counterpart of the pipe-in checker / pipe-out generator pair. Drives write strobes and pattern data into a pipe-in consumer, or read strobes into a pipe-out producer while checking the returned data. Used for on-chip loopback self-test of pipe endpoints and pattern logic without a host.

Parameters:
BLOCK_LEN, 256, words per block; power of two, 2..1024
READY_TIMEOUT, 1024, max cycles spent waiting for ready before abort

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; launches a transfer when idle
dir  in  1  0 = write (drive pipe-in), 1 = read (drive pipe-out)
num_blocks  in  16  blocks to transfer; 0 = none
pattern  in  3  0 counter, 1 LFSR, 2 walking-one, 3 fixed, 4-7 = counter
fixed_pattern  in  32  word used by pattern 3
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of transfer
timeout_err  out  1  sticky; set on ready timeout, cleared by start
error_count  out  32  read-side mismatches, saturating, cleared by start
pi_write  out  1  write strobe to pipe-in consumer
pi_blockstrobe  out  1  precedes each pipe-in block
pi_data  out  32  write data
pi_ready  in  1  consumer can accept a full block
po_read  out  1  read strobe to pipe-out producer
po_blockstrobe  out  1  precedes each pipe-out block
po_data  in  32  read data, valid the cycle after po_read
po_ready  in  1  producer has a full block

Behaviour:
- Reset: all outputs 0; FSM in IDLE; generator cleared.
- start ignored unless IDLE. On accept: latch dir, num_blocks, pattern, fixed_pattern; clear error_count and timeout_err; reload generator; busy=1 next cycle.
- FSM: IDLE -> WAIT_RDY -> BSTROBE -> XFER -> (WAIT_RDY | FLUSH) -> DONE -> IDLE.
- num_blocks=0: IDLE -> DONE directly; done pulses 2 cycles after start; no strobes.
- WAIT_RDY: selected ready (pi_ready or po_ready) sampled high -> BSTROBE. Timeout counter counts cycles with ready low; reaching READY_TIMEOUT sets timeout_err -> DONE.
- BSTROBE: selected blockstrobe high exactly one cycle, then XFER.
- XFER: selected strobe asserted on consecutive cycles (subject to optional throttle) until BLOCK_LEN strobes issued. Ready is not resampled mid-block. After last strobe: blocks remaining -> WAIT_RDY, else FLUSH (read) or DONE (write).
- FLUSH: one cycle, so the final read word is compared.
- DONE: done=1 one cycle, busy drops the same cycle.
- Write data: pi_data = generator value during each pi_write cycle; generator advances after each strobe. pi_data is 0 when pi_write is low.
- Read check: on the cycle after each po_read, compare po_data to expected; mismatch -> error_count+1, saturate at 32'hFFFFFFFF. Expected advances per compared word.
- Generator: counter starts 0, +1 wrapping. LFSR seed 32'h0D0C0B0A, next = {v[30:0], v[31]^v[21]^v[1]^v[0]}. Walking-one starts 32'h1, rotate left, wraps bit31->bit0. Fixed = fixed_pattern every word.
- Generator state is continuous across blocks within one transfer.
- reset mid-transfer: immediate return to IDLE, strobes low next cycle, no done pulse.
- Unselected direction's strobes stay 0 throughout.

Optional Feature:
THROTTLE_EN defined: extra input throttle_val[31:0], latched at start into a rotating mask. In XFER, a strobe is issued only when mask bit0=1; the mask rotates right every XFER cycle. A mask of 0 is treated as all-ones. Not defined: no port; strobe every XFER cycle.

Test Plan:
- Write, pattern 0, num_blocks=2, BLOCK_LEN=4, pi_ready=1 -> 1 blockstrobe + 4 writes per block, data 0..7, done once, error_count=0.
- Read, pattern 1, producer returns correct LFSR words; word 3 corrupted by XOR 1 -> error_count=1.
- pi_ready held 0, READY_TIMEOUT=16 -> timeout_err=1, done pulses ~17 cycles after busy rises, no pi_write.
- num_blocks=0 -> done 2 cycles after start, zero strobes; start pulsed while busy is ignored.
- Pattern 2, 40 words -> word 32 = 32'h1 (wrap); pattern 3 with fixed_pattern=32'hA5A5A5A5 -> every word matches.
- THROTTLE_EN, throttle_val=32'h55555555 -> strobes on alternate cycles, block of 4 spans 8 XFER cycles.

Source files
------------

// File: rtl/bt_pipe_initiator_if.sv
// bt_pipe_initiator_if: pipe-side bus of the block-throttled pipe initiator.
// Carries the pipe-in (write) and pipe-out (read) strobes, data and ready
// flags. The initiator uses the master modport; the endpoint (or a bench
// model of one) uses the slave modport.
interface bt_pipe_initiator_if;
  // pipe-in consumer side
  logic        pi_write;
  logic        pi_blockstrobe;
  logic [31:0] pi_data;
  logic        pi_ready;
  // pipe-out producer side
  logic        po_read;
  logic        po_blockstrobe;
  logic [31:0] po_data;
  logic        po_ready;

  modport master (
    output pi_write,
    output pi_blockstrobe,
    output pi_data,
    input  pi_ready,
    output po_read,
    output po_blockstrobe,
    input  po_data,
    input  po_ready
  );

  modport slave (
    input  pi_write,
    input  pi_blockstrobe,
    input  pi_data,
    output pi_ready,
    input  po_read,
    input  po_blockstrobe,
    output po_data,
    output po_ready
  );
endinterface

// File: rtl/bt_pipe_initiator.sv
// bt_pipe_initiator: host-side initiator for the block-throttled pipe
// protocol. Writes generated pattern blocks into a pipe-in consumer, or
// reads blocks from a pipe-out producer and counts words that differ from
// the same pattern.
//
// Optional feature macro: THROTTLE_EN
//   When defined, an extra input throttle_val is latched at start into a
//   rotating mask; a strobe is only issued on XFER cycles where the mask
//   bit0 is set. A zero mask means "strobe every cycle".
module bt_pipe_initiator #(
  parameter int BLOCK_LEN     = 256,   // words per block, power of two
  parameter int READY_TIMEOUT = 1024   // max ready-low cycles before abort
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        dir,
  input  logic [15:0] num_blocks,
  input  logic [2:0]  pattern,
  input  logic [31:0] fixed_pattern,
`ifdef THROTTLE_EN
  input  logic [31:0] throttle_val,
`endif
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [31:0] error_count,
  bt_pipe_initiator_if.master pipe
);

  localparam int CW = $clog2(BLOCK_LEN);
  localparam int TW = $clog2(READY_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(BLOCK_LEN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(READY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_BSTROBE,
    S_XFER,
    S_FLUSH,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------
  // Pattern generator rules (shared by write data and read expectation)
  // ---------------------------------------------------------------------
  function automatic logic [31:0] gen_seed(input logic [2:0]  pat,
                                           input logic [31:0] fx);
    case (pat)
      3'd1:    gen_seed = 32'h0D0C0B0A;
      3'd2:    gen_seed = 32'h0000_0001;
      3'd3:    gen_seed = fx;
      default: gen_seed = 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] gen_next(input logic [2:0]  pat,
                                           input logic [31:0] v,
                                           input logic [31:0] fx);
    case (pat)
      3'd1:    gen_next = {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
      3'd2:    gen_next = {v[30:0], v[31]};
      3'd3:    gen_next = fx;
      default: gen_next = v + 32'd1;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t        state_q;
  logic          busy_q;
  logic          done_q;
  logic          timeout_err_q;
  logic          dir_q;
  logic [2:0]    pat_q;
  logic [31:0]   fixed_q;
  logic [15:0]   blk_q;        // blocks still to transfer, incl. current
  logic [CW-1:0] cnt_q;        // strobes issued in the current block
  logic [TW-1:0] to_cnt_q;     // ready-low cycles in the current wait
  logic          pi_write_q;
  logic          pi_bs_q;
  logic          po_read_q;
  logic          po_bs_q;

  logic [31:0]   gen_q,      gen_d;
  logic [31:0]   pi_data_q,  pi_data_d;
  logic [31:0]   err_q,      err_d;
  logic          rd_d1_q,    rd_d1_d;   // a read was issued last cycle

  logic          rdy_sel;
  logic          strobe_now;
  logic          last_strobe;
  logic          accept;
  logic          issue;                 // schedule a strobe for next cycle
  logic          bs_gate;               // strobe allowed in first XFER cycle
  logic          xf_gate;               // strobe allowed in following cycle

`ifdef THROTTLE_EN
  logic [31:0]   mask_q;
  // bit0 of the mask gates the current XFER cycle; after a right rotate
  // the next cycle is gated by what is now bit1.
  assign bs_gate = mask_q[0];
  assign xf_gate = mask_q[1];
`else
  assign bs_gate = 1'b1;
  assign xf_gate = 1'b1;
`endif

  // Control decode: which ready is watched and whether a strobe goes out next
  always_comb begin
    rdy_sel     = dir_q ? pipe.po_ready : pipe.pi_ready;
    strobe_now  = pi_write_q | po_read_q;
    last_strobe = strobe_now && (cnt_q == LAST_IDX);
    accept      = (state_q == S_IDLE) && start;
    issue       = 1'b0;
    if (state_q == S_BSTROBE) begin
      issue = bs_gate;
    end else if ((state_q == S_XFER) && !last_strobe) begin
      issue = xf_gate;
    end
  end

  // Datapath next-state: generator advance, write data, read compare
  always_comb begin
    gen_d     = gen_q;
    pi_data_d = 32'h0;
    err_d     = err_q;
    rd_d1_d   = po_read_q;
    if (issue && !dir_q) begin
      pi_data_d = gen_q;
    end
    if (accept) begin
      gen_d = gen_seed(pattern, fixed_pattern);
      err_d = 32'h0;
    end else begin
      // writes consume a word per strobe, reads per compared word
      if (dir_q ? rd_d1_q : issue) begin
        gen_d = gen_next(pat_q, gen_q, fixed_q);
      end
      if (rd_d1_q && (pipe.po_data != gen_q) && (err_q != 32'hFFFF_FFFF)) begin
        err_d = err_q + 32'd1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      gen_q     <= 32'h0;
      pi_data_q <= 32'h0;
      err_q     <= 32'h0;
      rd_d1_q   <= 1'b0;
    end else begin
      gen_q     <= gen_d;
      pi_data_q <= pi_data_d;
      err_q     <= err_d;
      rd_d1_q   <= rd_d1_d;
    end
  end

  // Transfer sequencer with registered strobes and status
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      dir_q         <= 1'b0;
      pat_q         <= 3'd0;
      fixed_q       <= 32'h0;
      blk_q         <= 16'd0;
      cnt_q         <= '0;
      to_cnt_q      <= '0;
      pi_write_q    <= 1'b0;
      pi_bs_q       <= 1'b0;
      po_read_q     <= 1'b0;
      po_bs_q       <= 1'b0;
`ifdef THROTTLE_EN
      mask_q        <= 32'h0;
`endif
    end else begin
      done_q     <= 1'b0;
      pi_bs_q    <= 1'b0;
      po_bs_q    <= 1'b0;
      pi_write_q <= issue && !dir_q;
      po_read_q  <= issue && dir_q;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            dir_q         <= dir;
            pat_q         <= pattern;
            fixed_q       <= fixed_pattern;
            blk_q         <= num_blocks;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b1;
            cnt_q         <= '0;
            to_cnt_q      <= '0;
`ifdef THROTTLE_EN
            mask_q        <= (throttle_val == 32'h0) ? 32'hFFFF_FFFF : throttle_val;
`endif
            state_q       <= (num_blocks == 16'd0) ? S_DONE : S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: begin
          if (rdy_sel) begin
            to_cnt_q <= '0;
            pi_bs_q  <= !dir_q;
            po_bs_q  <= dir_q;
            state_q  <= S_BSTROBE;
          end else if (to_cnt_q == TO_LAST) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_DONE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        S_BSTROBE: begin
          cnt_q   <= '0;
          state_q <= S_XFER;
        end
        S_XFER: begin
`ifdef THROTTLE_EN
          mask_q <= {mask_q[0], mask_q[31:1]};
`endif
          if (strobe_now) begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (last_strobe) begin
            blk_q <= blk_q - 16'd1;
            if (blk_q == 16'd1) begin
              // a read still has its last word in flight
              state_q <= dir_q ? S_FLUSH : S_DONE;
            end else begin
              state_q <= S_WAIT_RDY;
            end
          end
        end
        S_FLUSH: begin
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign timeout_err         = timeout_err_q;
  assign error_count         = err_q;
  assign pipe.pi_write       = pi_write_q;
  assign pipe.pi_blockstrobe = pi_bs_q;
  assign pipe.pi_data        = pi_data_q;
  assign pipe.po_read        = po_read_q;
  assign pipe.po_blockstrobe = po_bs_q;

endmodule

// File: tb/tb_bt_pipe_initiator.sv
// tb_bt_pipe_initiator: self-checking bench for bt_pipe_initiator with
// BLOCK_LEN=4 and READY_TIMEOUT=16. A pipe-out producer model answers
// reads from a table of expected words (optionally corrupted); a monitor
// logs write data and strobes. Expectations come from a word-index model
// of each pattern. Throttle scenarios are built only with THROTTLE_EN.
`timescale 1ns/1ps
module tb_bt_pipe_initiator;
  localparam int BL = 4;
  localparam int RT = 16;
  localparam byte EV_B = 8'd1;
  localparam byte EV_W = 8'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        dir;
  logic [15:0] num_blocks;
  logic [2:0]  pattern;
  logic [31:0] fixed_pattern;
`ifdef THROTTLE_EN
  logic [31:0] throttle_val;
`endif
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [31:0] error_count;

  bt_pipe_initiator_if pif ();

  bt_pipe_initiator #(.BLOCK_LEN(BL), .READY_TIMEOUT(RT)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .dir           (dir),
    .num_blocks    (num_blocks),
    .pattern       (pattern),
    .fixed_pattern (fixed_pattern),
`ifdef THROTTLE_EN
    .throttle_val  (throttle_val),
`endif
    .busy          (busy),
    .done          (done),
    .timeout_err   (timeout_err),
    .error_count   (error_count),
    .pipe          (pif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  bit rnd_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // word k of a transfer using pattern pat, from the pattern definitions
  function automatic logic [31:0] model_word(input int pat, input int k, input logic [31:0] fx);
    logic [31:0] v;
    case (pat)
      1: begin
        v = 32'h0D0C0B0A;
        for (int i = 0; i < k; i++) v = {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
      end
      2:       v = 32'h1 << (k % 32);
      3:       v = fx;
      default: v = 32'(k);
    endcase
    return v;
  endfunction

  // ---- monitor: log everything the DUT drives, sampled mid-cycle ----
  logic [31:0] wq[$];
  int          wcyc[$];
  byte         evq[$];
  int done_cnt = 0, done_cyc = 0, busy_rise_cyc = 0;
  int pi_bs_cnt = 0, po_bs_cnt = 0, po_rd_cnt = 0, idle_data_cnt = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (pif.pi_write === 1'b1) begin
      wq.push_back(pif.pi_data);
      wcyc.push_back(cyc);
      evq.push_back(EV_W);
    end else if (pif.pi_data !== 32'h0) begin
      idle_data_cnt++;
    end
    if (pif.pi_blockstrobe === 1'b1) begin
      pi_bs_cnt++;
      evq.push_back(EV_B);
    end
    if (pif.po_blockstrobe === 1'b1) po_bs_cnt++;
    if (pif.po_read === 1'b1) po_rd_cnt++;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy === 1'b1 && busy_prev !== 1'b1) busy_rise_cyc = cyc;
    busy_prev = busy;
  end

  // ---- pipe-out producer: data valid the cycle after each read ----
  logic [31:0] rd_words [64];
  int rd_idx = 0;
  int rd_base = 0;
  bit rd_prev = 1'b0;

  always @(negedge clk) begin
    if (rd_prev) begin
      pif.po_data = rd_words[(rd_idx - rd_base) & 63];
      rd_idx++;
    end else begin
      pif.po_data = $urandom;
    end
    rd_prev = (pif.po_read === 1'b1);
  end

  // Launch one transfer and wait (bounded) for its done pulse
  task automatic do_transfer(input bit d, input int nb, input int pat, input logic [31:0] fx,
                             input int max_cyc, input int poke_at, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    @(negedge clk); #1;
    dir = d; num_blocks = 16'(nb); pattern = 3'(pat); fixed_pattern = fx;
    start = 1'b1;
    start_cyc = cyc;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk); #1;
      start = (i == poke_at);
      if (start) begin
        dir = ~d; num_blocks = 16'd7; pattern = 3'd2;
      end
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
      if (rnd_ready) begin
        pif.pi_ready = ($urandom_range(0, 3) != 0);
        pif.po_ready = ($urandom_range(0, 3) != 0);
      end
    end
    start = 1'b0;
    $display("xfer dir=%0d pat=%0d nb=%0d cycles=%0d err_cnt=%0d tmo=%0d done=%0d",
             d, pat, nb, cyc - start_cyc, error_count, timeout_err, ok);
  endtask

  task automatic test_reset();
    logic [31:0] obs [9];
    logic [31:0] req [9];
    string nm [9];
    reset = 1'b1; start = 1'b0; dir = 1'b0; num_blocks = 16'd0; pattern = 3'd0;
    fixed_pattern = 32'h0; pif.pi_ready = 1'b0; pif.po_ready = 1'b0;
`ifdef THROTTLE_EN
    throttle_val = 32'h0;
`endif
    repeat (3) @(negedge clk);
    obs[0] = 32'(busy);               nm[0] = "rst_busy";
    obs[1] = 32'(done);               nm[1] = "rst_done";
    obs[2] = 32'(timeout_err);        nm[2] = "rst_timeout_err";
    obs[3] = error_count;             nm[3] = "rst_error_count";
    obs[4] = 32'(pif.pi_write);       nm[4] = "rst_pi_write";
    obs[5] = 32'(pif.pi_blockstrobe); nm[5] = "rst_pi_blockstrobe";
    obs[6] = pif.pi_data;             nm[6] = "rst_pi_data";
    obs[7] = 32'(pif.po_read);        nm[7] = "rst_po_read";
    obs[8] = 32'(pif.po_blockstrobe); nm[8] = "rst_po_blockstrobe";
    for (int i = 0; i < 9; i++) req[i] = 32'h0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs[i] !== req[i]) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", nm[i], obs[i], req[i]);
      end
    end
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  // Write scenario: data stream, block framing, single done, quiet read side
  task automatic test_write_case(input string tag, input int pat, input int nb, input logic [31:0] fx,
                                 input bit rnd, input int poke_at);
    int w0, e0, bs0, pb0, pr0, id0, d0, nw, bad;
    bit ok;
    logic [31:0] req;
    w0 = wq.size(); e0 = evq.size(); bs0 = pi_bs_cnt; pb0 = po_bs_cnt;
    pr0 = po_rd_cnt; id0 = idle_data_cnt; d0 = done_cnt;
    rnd_ready = rnd; pif.pi_ready = 1'b1; pif.po_ready = 1'b0;
    do_transfer(1'b0, nb, pat, fx, 600, poke_at, ok);
    rnd_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_done_seen: got 0 expected 1", tag); end
    nw = wq.size() - w0;
    checks++;
    if (nw != nb * BL) begin errors++; $display("FAIL %s_write_count: got %0d expected %0d", tag, nw, nb * BL); end
    for (int k = 0; k < nw; k++) begin
      req = model_word(pat, k, fx);
      checks++;
      if (wq[w0 + k] !== req) begin
        errors++;
        $display("FAIL %s_word%0d: got %h expected %h", tag, k, wq[w0 + k], req);
      end
    end
    bad = 0;
    for (int j = 0; j < evq.size() - e0; j++)
      if (evq[e0 + j] != (((j % (BL + 1)) == 0) ? EV_B : EV_W)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s_block_framing: got %0d misplaced expected 0", tag, bad); end
    checks++;
    if (pi_bs_cnt - bs0 != nb) begin errors++; $display("FAIL %s_pi_blockstrobes: got %0d expected %0d", tag, pi_bs_cnt - bs0, nb); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL %s_done_pulses: got %0d expected 1", tag, done_cnt - d0); end
    checks++;
    if ((po_rd_cnt - pr0) + (po_bs_cnt - pb0) != 0) begin
      errors++; $display("FAIL %s_po_strobes: got %0d expected 0", tag, (po_rd_cnt - pr0) + (po_bs_cnt - pb0));
    end
    checks++;
    if (idle_data_cnt - id0 != 0) begin errors++; $display("FAIL %s_idle_data_nonzero: got %0d expected 0", tag, idle_data_cnt - id0); end
    checks++;
    if (error_count !== 32'h0 || timeout_err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_status: got err=%0d tmo=%0b busy=%0b expected 0 0 0", tag, error_count, timeout_err, busy);
    end
  endtask

  // Read scenario: producer returns pattern words, some corrupted
  task automatic test_read_case(input string tag, input int pat, input int nb, input logic [31:0] fx,
                                input bit rnd, input int corrupt_idx, input bit rnd_corrupt);
    int w0, bs0, pb0, pr0, d0, nerr;
    bit ok;
    nerr = 0;
    for (int k = 0; k < 64; k++) begin
      rd_words[k] = model_word(pat, k, fx);
      if (k < nb * BL && (k == corrupt_idx || (rnd_corrupt && $urandom_range(0, 5) == 0))) begin
        rd_words[k] = rd_words[k] ^ (32'h1 << ((k == corrupt_idx) ? 0 : $urandom_range(0, 31)));
        nerr++;
      end
    end
    rd_base = rd_idx;
    w0 = wq.size(); bs0 = pi_bs_cnt; pb0 = po_bs_cnt; pr0 = po_rd_cnt; d0 = done_cnt;
    rnd_ready = rnd; pif.pi_ready = 1'b0; pif.po_ready = 1'b1;
    do_transfer(1'b1, nb, pat, fx, 600, -1, ok);
    rnd_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_done_seen: got 0 expected 1", tag); end
    checks++;
    if (error_count !== 32'(nerr)) begin errors++; $display("FAIL %s_error_count: got %0d expected %0d", tag, error_count, nerr); end
    checks++;
    if (po_rd_cnt - pr0 != nb * BL) begin errors++; $display("FAIL %s_read_count: got %0d expected %0d", tag, po_rd_cnt - pr0, nb * BL); end
    checks++;
    if (po_bs_cnt - pb0 != nb) begin errors++; $display("FAIL %s_po_blockstrobes: got %0d expected %0d", tag, po_bs_cnt - pb0, nb); end
    checks++;
    if ((wq.size() - w0) + (pi_bs_cnt - bs0) != 0) begin
      errors++; $display("FAIL %s_pi_strobes: got %0d expected 0", tag, (wq.size() - w0) + (pi_bs_cnt - bs0));
    end
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_done_busy: got done=%0d busy=%0b expected 1 0", tag, done_cnt - d0, busy);
    end
  endtask

  task automatic test_write_counter();
    test_write_case("wr_cnt", 0, 2, 32'h0, 1'b0, 3);   // start poked mid-transfer
  endtask

  task automatic test_write_random();
    for (int i = 0; i < 4; i++)
      test_write_case("wr_rnd", $urandom_range(0, 7), $urandom_range(1, 4), $urandom, 1'b1, -1);
  endtask

  task automatic test_read_lfsr();
    test_read_case("rd_lfsr", 1, 2, 32'h0, 1'b0, 3, 1'b0);
  endtask

  task automatic test_read_random();
    for (int i = 0; i < 4; i++)
      test_read_case("rd_rnd", $urandom_range(0, 7), $urandom_range(1, 4), $urandom, 1'b1, -1, 1'b1);
  endtask

  task automatic test_timeout();
    int w0, bs0;
    bit ok;
    w0 = wq.size(); bs0 = pi_bs_cnt;
    pif.pi_ready = 1'b0; pif.po_ready = 1'b1;
    do_transfer(1'b0, 1, 0, 32'h0, 100, -1, ok);
    @(negedge clk); #1;
    checks++;
    if (!ok) begin errors++; $display("FAIL tmo_done_seen: got 0 expected 1"); end
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %0b expected 1", timeout_err); end
    checks++;
    if (done_cyc - busy_rise_cyc != RT + 1) begin
      errors++; $display("FAIL tmo_latency: got %0d expected %0d", done_cyc - busy_rise_cyc, RT + 1);
    end
    checks++;
    if ((wq.size() - w0) + (pi_bs_cnt - bs0) != 0) begin
      errors++; $display("FAIL tmo_strobes: got %0d expected 0", (wq.size() - w0) + (pi_bs_cnt - bs0));
    end
  endtask

  task automatic test_zero_blocks();
    int w0, bs0, pb0, pr0, d0;
    bit ok;
    w0 = wq.size(); bs0 = pi_bs_cnt; pb0 = po_bs_cnt; pr0 = po_rd_cnt; d0 = done_cnt;
    pif.pi_ready = 1'b1; pif.po_ready = 1'b1;
    do_transfer(1'b0, 0, 0, 32'h0, 20, 0, ok);        // start poked while busy
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (!ok || done_cyc - start_cyc != 2) begin
      errors++; $display("FAIL zero_done_latency: got %0d expected 2", done_cyc - start_cyc);
    end
    checks++;
    if (busy_rise_cyc - start_cyc != 1) begin
      errors++; $display("FAIL zero_busy_latency: got %0d expected 1", busy_rise_cyc - start_cyc);
    end
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_ignored_start: got done=%0d busy=%0b expected 1 0", done_cnt - d0, busy);
    end
    checks++;
    if ((wq.size() - w0) + (pi_bs_cnt - bs0) + (po_bs_cnt - pb0) + (po_rd_cnt - pr0) != 0) begin
      errors++; $display("FAIL zero_strobes: got some expected 0");
    end
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL zero_timeout_cleared: got %0b expected 0", timeout_err); end
  endtask

  task automatic test_walking();
    int w0;
    w0 = wq.size();
    test_write_case("walk", 2, 10, 32'h0, 1'b0, -1);
    checks++;
    if (wq.size() < w0 + 33 || wq[w0 + 32] !== 32'h1) begin
      errors++; $display("FAIL walk_wrap_word32: got %h expected 00000001", (wq.size() > w0 + 32) ? wq[w0 + 32] : 32'hx);
    end
  endtask

  task automatic test_fixed();
    test_write_case("fix_wr", 3, 2, 32'hA5A5A5A5, 1'b0, -1);
    test_read_case("fix_rd", 3, 2, 32'hA5A5A5A5, 1'b0, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int d0, w1, i;
    d0 = done_cnt;
    pif.pi_ready = 1'b1;
    @(negedge clk); #1;
    dir = 1'b0; num_blocks = 16'd3; pattern = 3'd0; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    i = 0;
    while (pif.pi_write !== 1'b1 && i < 30) begin
      @(negedge clk); #1;
      i++;
    end
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    checks++;
    if (pif.pi_write !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_strobe_busy: got wr=%0b busy=%0b expected 0 0", pif.pi_write, busy);
    end
    w1 = wq.size();
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (done_cnt != d0 || wq.size() != w1) begin
      errors++; $display("FAIL midrst_quiet: got done=%0d writes=%0d expected 0 0", done_cnt - d0, wq.size() - w1);
    end
    $display("xfer midrst reset after %0d wait cycles", i);
  endtask

`ifdef THROTTLE_EN
  task automatic test_throttle();
    int c0, gap;
    bit ok;
    logic [31:0] tv [2];
    tv[0] = 32'h55555555;
    tv[1] = 32'h0;
    for (int t = 0; t < 2; t++) begin
      throttle_val = tv[t];
      c0 = wcyc.size();
      test_write_case("thr", 0, 1, 32'h0, 1'b0, -1);
      for (int k = 1; k < wcyc.size() - c0; k++) begin
        gap = wcyc[c0 + k] - wcyc[c0 + k - 1];
        checks++;
        if (gap != ((t == 0) ? 2 : 1)) begin
          errors++; $display("FAIL thr_gap%0d: got %0d expected %0d", k, gap, (t == 0) ? 2 : 1);
        end
      end
    end
    throttle_val = 32'h0;
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_counter();
    test_read_lfsr();
    test_timeout();
    test_zero_blocks();
    test_walking();
    test_fixed();
    test_write_random();
    test_read_random();
    test_reset_mid();
`ifdef THROTTLE_EN
    test_throttle();
`endif
    test_write_case("post_rst", 1, 1, 32'h0, 1'b0, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
